// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters, transmit state encoding and
// a constant clog2 helper used to size counters in both UART directions.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Ceiling log2 with a floor of 1 bit so a counter never collapses to zero width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each
// bit. Holding clear parks the count at 0 so the next bit starts a full period.
module uart_baud_div
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int            CW   = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // NOTE: clocked state is only ever assigned with <=, so every flop samples the
  // pre-edge value of its neighbours regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, LSB-first framing with one start and
// one stop bit. Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TxD,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int            BW       = clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_e            state;
  tx_state_e            state_next;
  logic                 bit_tick;
  logic                 div_clear;
  logic                 accept;
  logic                 last_bit;
  logic                 txd_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [BW-1:0]        bit_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign accept    = tx_valid && (state == TX_IDLE);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign div_clear = (state == TX_IDLE);

  uart_baud_div #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_div (
    .clk     (clk),
    .rst     (rst),
    .clear   (div_clear),
    .bit_tick(bit_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  // NOTE: state_next takes a default before the case so no path leaves it
  // unassigned; without it synthesis would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (accept)   state_next = TX_START;
      TX_START: if (bit_tick) state_next = TX_DATA;
      TX_DATA: begin
        if (bit_tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_next = TX_PARITY;
`else
          state_next = TX_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: if (bit_tick) state_next = TX_STOP;
`endif
      TX_STOP:  if (bit_tick) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // Shift register input: load on handshake, shift out one bit per data tick.
  always_comb begin
    shift_next = shift_reg;
    if (accept) begin
      shift_next = tx_data;
    end else if ((state == TX_DATA) && bit_tick) begin
      shift_next = shift_reg >> 1;
    end
  end

  // NOTE: the shift register is reset too, so an abandoned frame leaves no
  // stale byte behind; it is a handful of flops, not a memory array.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      shift_reg <= shift_next;
      if (state == TX_IDLE) begin
        bit_cnt <= '0;
      end else if ((state == TX_DATA) && bit_tick) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity is captured with the byte since the shift register is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^tx_data;
    end
  end
`endif

  // Output logic; the line level is decoded from the upcoming state and then
  // registered so TxD changes exactly on bit boundaries with no glitches.
  always_comb begin
    tx_ready = (state == TX_IDLE);
    busy     = (state != TX_IDLE);
    tx_done  = (state == TX_STOP) && bit_tick;
    txd_next = 1'b1;
    case (state_next)
      TX_START:  txd_next = 1'b0;
      TX_DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: txd_next = parity;
`endif
      default:   txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      TxD <= 1'b1;
    end else begin
      TxD <= txd_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveforms are built from the
// frame definition (start, LSB-first data, optional parity, stop) per bit period.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [DB-1:0] tx_data  = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          TxD;
  logic          busy;
  logic          tx_done;

  int tests           = 0;
  int failures        = 0;
  int cycle           = 0;
  int last_done_cycle = 0;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TxD     (TxD),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line level during bit slot j of a frame carrying d.
  function automatic logic frame_bit(input logic [DB-1:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= DB) return d[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == DB + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " TxD"},      32'(TxD),      32'd1);
    check({tag, " tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, " busy"},     32'(busy),     32'd0);
    check({tag, " tx_done"},  32'(tx_done),  32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first
  // cycle after the frame, where a new byte may be presented immediately.
  task automatic send_frame(input logic [DB-1:0] data, input bit scramble, input bit hold_valid);
    check("ready before send", 32'(tx_ready), 32'd1);
    tx_data  = data;
    tx_valid = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      check($sformatf("TxD byte %02h cycle %0d", data, k), 32'(TxD), 32'(frame_bit(data, (k - 1) / CPB)));
      check($sformatf("tx_ready byte %02h cycle %0d", data, k), 32'(tx_ready), 32'd0);
      check($sformatf("busy byte %02h cycle %0d", data, k), 32'(busy), 32'd1);
      check($sformatf("tx_done byte %02h cycle %0d", data, k), 32'(tx_done), 32'(k == FRAME));
      if (tx_done === 1'b1) last_done_cycle = cycle;
      if (scramble) begin
        tx_data  = DB'($urandom);
        tx_valid = 1'($urandom_range(0, 1));
      end else if (!hold_valid) begin
        tx_valid = 1'b0;
      end
    end
    @(negedge clk);
    check($sformatf("ready after byte %02h", data), 32'(tx_ready), 32'd1);
    check($sformatf("busy after byte %02h", data), 32'(busy), 32'd0);
    check($sformatf("tx_done after byte %02h", data), 32'(tx_done), 32'd0);
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  initial begin
    int c_first;

    // Power-up reset held for three edges.
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle after reset");

    // Directed frames with known parity (0 for A5, 1 for 07).
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h07, 1'b0, 1'b0);

    // Back-to-back with tx_valid never dropping.
    c_first = cycle;
    for (int i = 0; i < 10; i++) begin
      send_frame((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b0, (i != 9));
    end
    check("10 frame span", 32'(last_done_cycle - c_first), 32'(10 * (FRAME + 1) - 1));

    // Reset in idle for three cycles.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle reset");
    end
    rst = 1'b0;

    // Reset during data bit 3 of 5A.
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    for (int k = 1; k <= 2 * CPB + 2; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      check($sformatf("abort TxD cycle %0d", k), 32'(TxD), 32'(frame_bit(8'h5A, (k - 1) / CPB)));
    end
    for (int k = 2 * CPB + 3; k <= 4 * CPB + 2; k++) begin
      @(negedge clk);
      check($sformatf("abort TxD cycle %0d", k), 32'(TxD), 32'(frame_bit(8'h5A, (k - 1) / CPB)));
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid-frame reset");
    rst = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      check($sformatf("no done after abort %0d", k), 32'(tx_done), 32'd0);
      check($sformatf("TxD idle after abort %0d", k), 32'(TxD), 32'd1);
    end
    send_frame(8'h3C, 1'b0, 1'b0);

    // Inputs toggled while busy must not disturb the latched byte.
    send_frame(8'hC3, 1'b1, 1'b0);

    // Random bytes, random idle gaps, random input noise during frames.
    for (int i = 0; i < 12; i++) begin
      repeat (int'($urandom_range(0, 3))) begin
        @(negedge clk);
        check_idle("gap");
      end
      send_frame(DB'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
